sync_handshake_rx: RTL and testbench

Destination-side end of the 4-phase req/ack clock-domain-crossing handshake. It synchronizes an asynchronous level request and captures the source-held data word. It presents that word on a local valid/ready interface and returns a registered acknowledge level to the source domain. It sits in the receiving clock domain opposite the source-side request/ack generator, so multi-bit values and events can cross between the simulator's fast and slow domains.

---
 rtl/sync_handshake_rx.sv | 114 +++++++++++
 tb/tb_sync_handshake_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_handshake_rx.sv
// Receiving-domain end of a 4-phase req/ack clock-domain-crossing handshake.
// The asynchronous request level is synchronized, and the source-held data
// word is captured once. The word is offered on a valid/ready interface, and
// a registered ack level is returned to the source.
//
// Parameters:
//   DATA_W       width of the transferred word
//   SYNC_STAGES  depth of the req synchronizer chain (legal range 2..4)
//   CNT_W        width of the completed-transfer counter (wraps)
//
// Ports:
//   clk, rst            receiving clock, async active-high reset
//   req_async           level request from the source domain
//   data_async          source data, stable while req is high until ack is seen
//   ack                 registered acknowledge level to the source domain
//   out_valid/out_ready local handshake for the captured word
//   out_data            captured word, held outside transfers
//   busy                high whenever the block is not idle
//   xfer_count          number of completed local transfers
module sync_handshake_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0]       xfer_count_q, xfer_count_d;
  logic                   req_sync;

  // Synchronizer chain: the only consumer of req_async.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
  end

  assign req_sync = sync_q[SYNC_STAGES-1];

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      ack_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_data_q   <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      ack_q        <= ack_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      out_data_q   <= out_data_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_sync)  state_d = ST_VALID;
      ST_VALID: if (out_ready) state_d = ST_ACK;
      ST_ACK:   if (!req_sync) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the output flops, so every output is a
  // plain flop with no decode glitches toward the source domain.
  always_comb begin
    out_data_d   = out_data_q;
    xfer_count_d = xfer_count_q;
    // data_async is sampled only on the IDLE -> VALID capture edge.
    if ((state_q == ST_IDLE) && req_sync) begin
      out_data_d = data_async;
    end
    if ((state_q == ST_VALID) && out_ready) begin
      xfer_count_d = xfer_count_q + CNT_W'(1);
    end
    ack_d       = (state_d == ST_ACK);
    out_valid_d = (state_d == ST_VALID);
    busy_d      = (state_d != ST_IDLE);
  end

  assign ack        = ack_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_data   = out_data_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_sync_handshake_rx.sv
// Directed and randomized checks for sync_handshake_rx (SYNC_STAGES=2, CNT_W=8).
module tb_sync_handshake_rx;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int          N_RAND      = 300;
  localparam int          CYC_BUDGET  = 20000;

  logic              clk;
  logic              rst;
  logic              req_async;
  logic [DATA_W-1:0] data_async;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  xfer_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;

  sync_handshake_rx #(
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_async (req_async),
    .data_async(data_async),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state for the randomized phase.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] prev_data;
  logic              prev_valid, prev_ready;
  int                sent, acc, cyc, phase;

  initial begin
    // ---- Reset with req and ready already high ----
    rst = 1'b1; req_async = 1'b1; out_ready = 1'b1; data_async = 8'h11;
    tick(); tick();
    check("rst_ack",   32'(ack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    rst = 1'b0;
    tick(); check("rel_e1_valid", 32'(out_valid), 32'd0);
    tick(); check("rel_e2_valid", 32'(out_valid), 32'd0);
    tick(); check("rel_cap_valid", 32'(out_valid), 32'd1);
    check("rel_cap_data", 32'(out_data), 32'h11);
    tick(); exp_count = 1;
    check("rel_acc_ack", 32'(ack), 32'd1);
    check("rel_acc_count", 32'(xfer_count), 32'(exp_count));
    req_async = 1'b0;
    tick(); tick(); tick();
    check("rel_ack_low", 32'(ack), 32'd0);

    // ---- Single transfer, 0xA5, ready held high ----
    data_async = 8'hA5; req_async = 1'b1;
    tick(); check("st_e1_valid", 32'(out_valid), 32'd0);
    tick(); check("st_e2_valid", 32'(out_valid), 32'd0);
    tick(); check("st_cap_valid", 32'(out_valid), 32'd1);
    check("st_cap_data", 32'(out_data), 32'hA5);
    check("st_cap_ack", 32'(ack), 32'd0);
    check("st_cap_busy", 32'(busy), 32'd1);
    tick(); exp_count++;
    check("st_acc_valid", 32'(out_valid), 32'd0);
    check("st_acc_ack", 32'(ack), 32'd1);
    check("st_acc_count", 32'(xfer_count), 32'(exp_count));
    req_async = 1'b0;
    tick(); check("st_drop1_ack", 32'(ack), 32'd1);
    tick(); check("st_drop2_ack", 32'(ack), 32'd1);
    tick(); check("st_drop3_ack", 32'(ack), 32'd0);
    check("st_idle_busy", 32'(busy), 32'd0);

    // ---- Backpressure: ready low for 10 cycles ----
    out_ready = 1'b0; data_async = 8'h3C; req_async = 1'b1;
    tick(); tick(); tick();
    check("bp_cap_valid", 32'(out_valid), 32'd1);
    data_async = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'h3C);
      check("bp_hold_ack", 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    tick(); exp_count++;
    check("bp_acc_valid", 32'(out_valid), 32'd0);
    check("bp_acc_ack", 32'(ack), 32'd1);
    check("bp_acc_count", 32'(xfer_count), 32'(exp_count));
    req_async = 1'b0;
    tick(); tick(); tick();
    check("bp_ack_low", 32'(ack), 32'd0);

    // ---- Early req drop while the word is pending ----
    out_ready = 1'b0; data_async = 8'h5A; req_async = 1'b1;
    tick(); tick(); tick();
    check("ed_cap_valid", 32'(out_valid), 32'd1);
    req_async = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ed_hold_valid", 32'(out_valid), 32'd1);
      check("ed_hold_data", 32'(out_data), 32'h5A);
    end
    out_ready = 1'b1;
    tick(); exp_count++;
    check("ed_acc_ack", 32'(ack), 32'd1);
    check("ed_acc_valid", 32'(out_valid), 32'd0);
    check("ed_acc_count", 32'(xfer_count), 32'(exp_count));
    tick();
    check("ed_one_cycle_ack", 32'(ack), 32'd0);
    check("ed_idle_busy", 32'(busy), 32'd0);

    // ---- Reset asserted while in ACK ----
    data_async = 8'h77; req_async = 1'b1;
    tick(); tick(); tick();
    check("mr_cap_valid", 32'(out_valid), 32'd1);
    tick();
    check("mr_ack_high", 32'(ack), 32'd1);
    rst = 1'b1;
    #1;
    check("mr_async_ack", 32'(ack), 32'd0);
    check("mr_async_count", 32'(xfer_count), 32'd0);
    check("mr_async_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0; exp_count = 0;
    tick(); tick(); tick();
    check("mr_recap_valid", 32'(out_valid), 32'd1);
    check("mr_recap_data", 32'(out_data), 32'h77);
    tick(); exp_count++;
    check("mr_acc_ack", 32'(ack), 32'd1);
    check("mr_acc_count", 32'(xfer_count), 32'd1);
    req_async = 1'b0;
    tick(); tick(); tick();
    check("mr_ack_low", 32'(ack), 32'd0);

    // ---- Randomized back-to-back transfers against a scoreboard ----
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_count = 0;
    tick();
    sent = 0; acc = 0; cyc = 0; phase = 0;
    while (acc < N_RAND && cyc < CYC_BUDGET) begin
      // Source: raise req with a fresh word, drop it once ack is seen,
      // and only re-raise after ack has been seen low again.
      case (phase)
        0: begin
          if (!ack && sent < N_RAND && $urandom_range(0, 3) != 0) begin
            w = DATA_W'($urandom);
            data_async = w;
            req_async = 1'b1;
            exp_q.push_back(w);
            sent++;
            phase = 1;
          end else begin
            data_async = DATA_W'($urandom);
          end
        end
        1: begin
          if (ack && $urandom_range(0, 2) != 0) begin
            req_async = 1'b0;
            phase = 2;
          end
        end
        default: begin
          data_async = DATA_W'($urandom);
          if (!ack) phase = 0;
        end
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      tick();
      cyc++;
      if (prev_valid && prev_ready) begin
        acc++;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        if (exp_q.size() == 0) begin
          check("rand_unexpected_word", 32'(prev_data), 32'hFFFF_FFFF);
        end else begin
          check("rand_data", 32'(prev_data), 32'(exp_q.pop_front()));
        end
        check("rand_count", 32'(xfer_count), 32'(exp_count));
      end
      check("rand_ack_valid_excl", 32'(ack & out_valid), 32'd0);
    end
    check("rand_budget", 32'(acc), 32'(N_RAND));
    check("rand_sent", 32'(sent), 32'(N_RAND));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rand_final_count", 32'(xfer_count), 32'(N_RAND % (1 << CNT_W)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
